// File: rtl/motor_spi_master.sv
// Mode-0 SPI master that ships a two-byte motor command (motor1 then motor2, MSB-first).
// Define MOTOR_SPI_READBACK_EN to capture sdi into rx_data; the default build has no rx_data port.
module motor_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [7:0] motor1,
  input  logic [7:0] motor2,
  output logic       ready,
  output logic       sck,
  output logic       sdo,
  output logic       cs_n,
  input  logic       sdi,
  output logic       done
`ifdef MOTOR_SPI_READBACK_EN
  ,
  output logic [15:0] rx_data
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic             w_tc;
  logic [15:0]      r_shift;
  logic [15:0]      w_shift_nxt;
  logic [4:0]       r_bitcnt;
  logic [4:0]       w_bitcnt_nxt;
  logic             r_sck;
  logic             r_sdo;
  logic             r_cs_n;
  logic             r_done;
  logic             w_sck_nxt;
  logic             w_sdo_nxt;
  logic             w_cs_n_nxt;
  logic             w_done_nxt;
  logic             w_rise;

  assign w_tc  = (r_div == DIV_TC);
  assign ready = (r_state == S_IDLE);
  assign sck   = r_sck;
  assign sdo   = r_sdo;
  assign cs_n  = r_cs_n;
  assign done  = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // SHIFT ends after a full trailing low phase once all 16 bits are out
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (valid) w_state_nxt = S_SETUP;
      S_SETUP: if (w_tc) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_tc && !r_sck && (r_bitcnt == 5'd0)) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tc) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sck_nxt    = r_sck;
    w_sdo_nxt    = r_sdo;
    w_cs_n_nxt   = r_cs_n;
    w_done_nxt   = 1'b0;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_rise       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sck_nxt  = 1'b0;
        w_cs_n_nxt = 1'b1;
        if (valid) begin
          w_shift_nxt  = {motor1, motor2};
          w_bitcnt_nxt = 5'd16;
          w_sdo_nxt    = motor1[7];
          w_cs_n_nxt   = 1'b0;
        end
      end
      S_SETUP: begin
        if (w_tc) begin
          w_sck_nxt = 1'b1;
          w_rise    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_tc) begin
          if (r_sck) begin
            // Falling edge: advance data, except after the last bit
            w_sck_nxt    = 1'b0;
            w_bitcnt_nxt = r_bitcnt - 5'd1;
            if (r_bitcnt != 5'd1) begin
              w_shift_nxt = {r_shift[14:0], 1'b0};
              w_sdo_nxt   = r_shift[14];
            end
          end else if (r_bitcnt != 5'd0) begin
            w_sck_nxt = 1'b1;
            w_rise    = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_tc) begin
          w_cs_n_nxt = 1'b1;
          w_done_nxt = 1'b1;
          w_sdo_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_sck    <= 1'b0;
      r_sdo    <= 1'b0;
      r_cs_n   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) || w_tc || (r_state == S_IDLE)) r_div <= '0;
      else r_div <= r_div + 1'b1;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sck    <= w_sck_nxt;
      r_sdo    <= w_sdo_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef MOTOR_SPI_READBACK_EN
  logic [15:0] r_rx_shift;
  logic [15:0] r_rx_data;

  // sdi is captured on each sck rise; the word is published as DONE is entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
    end else begin
      if (w_rise) r_rx_shift <= {r_rx_shift[14:0], sdi};
      if ((r_state == S_HOLD) && w_tc) r_rx_data <= r_rx_shift;
    end
  end

  assign rx_data = r_rx_data;
`else
  logic w_unused_rx;
  assign w_unused_rx = sdi | w_rise;
`endif

endmodule

// File: tb/tb_motor_spi_master.sv
// Bench for motor_spi_master: a CLK_DIV=4 and a CLK_DIV=2 instance with a model SPI receiver.
`timescale 1ns/1ps
module tb_motor_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       valid0, valid1;
  logic [7:0] m1_0, m2_0, m1_1, m2_1;
  logic       ready0, sck0, sdo0, cs_n0, sdi0, done0;
  logic       ready1, sck1, sdo1, cs_n1, sdi1, done1;
`ifdef MOTOR_SPI_READBACK_EN
  logic [15:0] rx_data0, rx_data1;
`endif

  motor_spi_master #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .valid(valid0), .motor1(m1_0), .motor2(m2_0),
    .ready(ready0), .sck(sck0), .sdo(sdo0), .cs_n(cs_n0), .sdi(sdi0), .done(done0)
`ifdef MOTOR_SPI_READBACK_EN
    , .rx_data(rx_data0)
`endif
  );

  motor_spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .valid(valid1), .motor1(m1_1), .motor2(m2_1),
    .ready(ready1), .sck(sck1), .sdo(sdo1), .cs_n(cs_n1), .sdi(sdi1), .done(done1)
`ifdef MOTOR_SPI_READBACK_EN
    , .rx_data(rx_data1)
`endif
  );

  localparam logic [15:0] SLAVE_WORD = 16'hBEEF;

  int checks = 0;
  int errors = 0;

  logic [15:0] expq0[$];
  logic [15:0] expq1[$];
  logic [31:0] rxq0[$];
  logic [31:0] rxq1[$];

  int          divv[2] = '{4, 2};
  int          run[2], rises[2], viol[2], badph[2], donecnt[2];
  logic [15:0] rxw[2], sdi_sh[2];
  logic        psck[2], psdo[2], pcs[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; rises[i] = 0; viol[i] = 0; badph[i] = 0; donecnt[i] = 0;
      rxw[i] = '0; sdi_sh[i] = '0; psck[i] = 1'b0; psdo[i] = 1'b0; pcs[i] = 1'b1;
    end
    sdi0 = 1'b0;
    sdi1 = 1'b0;
  end

  // Model receiver: samples sdo on sck rise, drives sdi (mode 0), checks phase widths
  logic        c_sck, c_sdo, c_cs, c_done;
  logic [31:0] pushv;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_sck  = (i == 0) ? sck0  : sck1;
      c_sdo  = (i == 0) ? sdo0  : sdo1;
      c_cs   = (i == 0) ? cs_n0 : cs_n1;
      c_done = (i == 0) ? done0 : done1;
      if (!reset_n) begin
        run[i] = 0; rises[i] = 0; rxw[i] = '0; sdi_sh[i] = '0;
        psck[i] = 1'b0; psdo[i] = 1'b0; pcs[i] = 1'b1;
      end else begin
        if (c_done) donecnt[i]++;
        if (!c_cs) begin
          if (pcs[i]) sdi_sh[i] = SLAVE_WORD;
          if (!psck[i] && c_sck) begin
            rxw[i] = {rxw[i][14:0], c_sdo};
            rises[i]++;
            if (c_sdo !== psdo[i]) viol[i]++;
          end
          if (psck[i] && !c_sck) sdi_sh[i] = {sdi_sh[i][14:0], 1'b0};
          if (c_sck == psck[i]) run[i]++;
          else begin
            if (run[i] != divv[i]) badph[i]++;
            run[i] = 1;
          end
        end else begin
          if (!pcs[i]) begin
            pushv = {16'(rises[i]), rxw[i]};
            if (i == 0) rxq0.push_back(pushv);
            else        rxq1.push_back(pushv);
          end
          rxw[i] = '0; rises[i] = 0; run[i] = 0;
        end
        psck[i] = c_sck; psdo[i] = c_sdo; pcs[i] = c_cs;
      end
    end
    sdi0 = sdi_sh[0][15];
    sdi1 = sdi_sh[1][15];
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Counts cycles until done; n enters holding cycles already elapsed since acceptance
  task automatic wait_done(input int idx, input int limit, inout int n);
    while (((idx == 0) ? done0 : done1) !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (((idx == 0) ? done0 : done1) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout inst%0d: no done after %0d cycles", idx, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    m1_0 = '0; m2_0 = '0; m1_1 = '0; m2_1 = '0;
    repeat (3) tick();
    checks++;
    if ({cs_n0, sck0, sdo0, done0} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got cs_n/sck/sdo/done=%b required 1000", {cs_n0, sck0, sdo0, done0});
    end
`ifdef MOTOR_SPI_READBACK_EN
    checks++;
    if (rx_data0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rx_data: got %h required 0000", rx_data0);
    end
`endif
    reset_n = 1'b1;
    tick();
    checks++;
    if ({ready0, ready1, cs_n1, sck1, done1} !== 5'b11100) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 11100", {ready0, ready1, cs_n1, sck1, done1});
    end
  endtask

  task automatic test_single();
    int          n;
    logic [31:0] got;
    expq0.push_back(16'hA53C);
    m1_0 = 8'hA5; m2_0 = 8'h3C; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    n = 1;
    checks++;
    if ({ready0, cs_n0} !== 2'b00) begin
      errors++;
      $display("FAIL single_busy: got ready/cs_n=%b required 00", {ready0, cs_n0});
    end
    wait_done(0, 400, n);
    checks++;
    if (n != 137) begin
      errors++;
      $display("FAIL single_length: got %0d cycles required 137", n);
    end
    checks++;
    if (cs_n0 !== 1'b1) begin
      errors++;
      $display("FAIL single_done_cs: got cs_n=%b required 1", cs_n0);
    end
`ifdef MOTOR_SPI_READBACK_EN
    checks++;
    if (rx_data0 !== SLAVE_WORD) begin
      errors++;
      $display("FAIL readback_done: got %h required %h", rx_data0, SLAVE_WORD);
    end
`endif
    got = (rxq0.size() > 0) ? rxq0.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (got[15:0] !== expq0.pop_front()) begin
      errors++;
      $display("FAIL single_word: got %h required a53c", got[15:0]);
    end
    checks++;
    if (got[31:16] !== 16'd16) begin
      errors++;
      $display("FAIL single_rises: got %0d required 16", got[31:16]);
    end
    tick();
    checks++;
    if ({done0, ready0} !== 2'b01) begin
      errors++;
      $display("FAIL single_done_pulse: got done/ready=%b required 01", {done0, ready0});
    end
`ifdef MOTOR_SPI_READBACK_EN
    repeat (5) tick();
    checks++;
    if (rx_data0 !== SLAVE_WORD) begin
      errors++;
      $display("FAIL readback_hold: got %h required %h", rx_data0, SLAVE_WORD);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [31:0] got;
    expq0.push_back(16'h0180);
    expq0.push_back(16'hFF00);
    m1_0 = 8'h01; m2_0 = 8'h80; valid0 = 1'b1;
    tick();
    m1_0 = 8'hFF; m2_0 = 8'h00;
    n = 1;
    wait_done(0, 400, n);
    checks++;
    if (n != 137) begin
      errors++;
      $display("FAIL b2b_length1: got %0d cycles required 137", n);
    end
    tick();
    checks++;
    if ({cs_n0, ready0} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_gap: got cs_n/ready=%b required 11", {cs_n0, ready0});
    end
    tick();
    valid0 = 1'b0;
    checks++;
    if (cs_n0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got cs_n=%b required 0", cs_n0);
    end
    n = 1;
    wait_done(0, 400, n);
    checks++;
    if (n != 137) begin
      errors++;
      $display("FAIL b2b_length2: got %0d cycles required 137", n);
    end
    for (int k = 0; k < 2; k++) begin
      got = (rxq0.size() > 0) ? rxq0.pop_front() : 32'hFFFF_FFFF;
      checks++;
      if (got[15:0] !== expq0[0]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h required %h", k, got[15:0], expq0[0]);
      end
      void'(expq0.pop_front());
    end
    tick();
  endtask

  task automatic test_input_hold();
    int          n;
    int          dc;
    logic [31:0] got;
    expq0.push_back(16'h7E7E);
    m1_0 = 8'h7E; m2_0 = 8'h7E; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    dc = donecnt[0];
    n = 1;
    while (done0 !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 20) m1_0 = 8'h00;
      valid0 = (n >= 30 && n <= 100 && (n % 10) == 0);
    end
    valid0 = 1'b0;
    checks++;
    if (n != 137) begin
      errors++;
      $display("FAIL hold_length: got %0d cycles required 137", n);
    end
    got = (rxq0.size() > 0) ? rxq0.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (got[15:0] !== expq0.pop_front()) begin
      errors++;
      $display("FAIL hold_word: got %h required 7e7e", got[15:0]);
    end
    repeat (200) tick();
    checks++;
    if (rxq0.size() != 0 || donecnt[0] != dc + 1) begin
      errors++;
      $display("FAIL hold_no_extra: got %0d frames/%0d dones required 0/%0d", rxq0.size(), donecnt[0], dc + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int          n;
    int          dc;
    logic [31:0] got;
    m1_0 = 8'h55; m2_0 = 8'hAA; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    n = 1;
    while (rises[0] != 9 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (rises[0] != 9) begin
      errors++;
      $display("FAIL abort_reach9: got %0d rises required 9", rises[0]);
    end
    dc = donecnt[0];
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sck0, cs_n0, done0} !== 3'b010) begin
      errors++;
      $display("FAIL abort_immediate: got sck/cs_n/done=%b required 010", {sck0, cs_n0, done0});
    end
    tick();
    tick();
    reset_n = 1'b1;
    expq0.push_back(16'h1234);
    m1_0 = 8'h12; m2_0 = 8'h34; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    checks++;
    if ({ready0, cs_n0} !== 2'b00) begin
      errors++;
      $display("FAIL abort_first_accept: got ready/cs_n=%b required 00", {ready0, cs_n0});
    end
    n = 1;
    wait_done(0, 400, n);
    checks++;
    if (n != 137 || donecnt[0] != dc + 1) begin
      errors++;
      $display("FAIL abort_next_frame: got %0d cycles/%0d dones required 137/%0d", n, donecnt[0], dc + 1);
    end
    got = (rxq0.size() > 0) ? rxq0.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (got[15:0] !== expq0.pop_front()) begin
      errors++;
      $display("FAIL abort_word: got %h required 1234", got[15:0]);
    end
    tick();
  endtask

  task automatic test_min_div();
    int          n;
    logic [31:0] got;
    expq1.push_back(16'hC35A);
    m1_1 = 8'hC3; m2_1 = 8'h5A; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    n = 1;
    wait_done(1, 200, n);
    checks++;
    if (n != 69) begin
      errors++;
      $display("FAIL div2_length: got %0d cycles required 69", n);
    end
    got = (rxq1.size() > 0) ? rxq1.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (got !== {16'd16, expq1.pop_front()}) begin
      errors++;
      $display("FAIL div2_word: got rises/word %h required 0010c35a", got);
    end
    checks++;
    if (badph[1] != 0 || viol[1] != 0) begin
      errors++;
      $display("FAIL div2_phases: got %0d bad phases %0d sdo-on-rise required 0/0", badph[1], viol[1]);
    end
    checks++;
    if (badph[0] != 0 || viol[0] != 0) begin
      errors++;
      $display("FAIL div4_phases: got %0d bad phases %0d sdo-on-rise required 0/0", badph[0], viol[0]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_input_hold();
    test_reset_mid_frame();
    test_min_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
